// File: rtl/mem_responder_pkg.sv
// Shared types and constants for the unified memory responder.
package mem_responder_pkg;

    localparam int WORD_BYTES  = 4;
    localparam int MAX_LATENCY = 15;
    localparam int CNT_W       = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    // Snapshot of one request, taken on the accepting edge.
    typedef struct packed {
        logic                      we;
        logic [31:0]               addr;
        logic [31:0]               wdata;
        logic [WORD_BYTES-1:0]     wstrb;
        logic                      fault;
    } req_t;

    // True when the byte address is misaligned or lies beyond the array.
    function automatic logic addrFault(input logic [31:0] addr, input int unsigned depthWords);
        return (addr[1:0] != 2'b00) || ({2'b00, addr[31:2]} >= depthWords);
    endfunction

endpackage

// File: rtl/mem_responder_if.sv
// Request/response bundle between the CPU datapath and the memory responder.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic                  req;
    logic                  we;
    logic [31:0]           addr;
    logic [31:0]           wdata;
    logic [WORD_BYTES-1:0] wstrb;
    logic [31:0]           rdata;
    logic                  ready;
    logic                  err;

    modport master (output req, we, addr, wdata, wstrb, input rdata, ready, err);
    modport slave  (input req, we, addr, wdata, wstrb, output rdata, ready, err);
endinterface

// File: rtl/mem_responder_array.sv
// Word-wide storage with byte-masked synchronous write and registered read.
// Contents survive reset on purpose: a CPU reset must not wipe program memory.
module mem_array
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  logic                  clk_i,
    input  logic                  en_i,
    input  logic                  we_i,
    input  logic [WORD_BYTES-1:0] wstrb_i,
    input  logic [AW-1:0]         waddr_i,
    input  logic [31:0]           wdata_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem [DEPTH_WORDS];
    logic [31:0] rdata_q;

    // One access per enable: masked byte write for stores, registered read otherwise.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            if (we_i) begin
                for (int i = 0; i < WORD_BYTES; i++) begin
                    if (wstrb_i[i]) begin
                        mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
                    end
                end
            end else begin
                rdata_q <= mem[waddr_i];
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder: accepts one request, waits LATENCY cycles, then
// performs the access and pulses ready (with err for faulted addresses).
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int DEPTH_WORDS = 256,
    parameter int LATENCY     = 2
) (
    input  logic            clk_i,
    input  logic            rst_i,
    mem_responder_if.slave  bus
);

    localparam int               AW       = $clog2(DEPTH_WORDS);
    localparam logic [CNT_W-1:0] CNT_INIT = (LATENCY > 0) ? CNT_W'(LATENCY - 1) : '0;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] waitCnt_q, waitCnt_d;
    req_t             reqLat_q, reqLat_d;
    req_t             incoming;
    req_t             access;
    logic             memEn;
    logic             ready_q, ready_d;
    logic             err_q, err_d;
    logic             rdSel_q, rdSel_d;
    logic [31:0]      arrRdata;
    logic             unusedAddrBits;

    assign incoming = '{we:    bus.we,
                        addr:  bus.addr,
                        wdata: bus.wdata,
                        wstrb: bus.wstrb,
                        fault: addrFault(bus.addr, DEPTH_WORDS)};

    // Sequencing: latch on accept, count down the wait, fire the access on the edge entering RESP.
    // With zero latency the accepting edge is also the access edge, so the live inputs are used.
    always_comb begin
        state_d   = state_q;
        waitCnt_d = waitCnt_q;
        reqLat_d  = reqLat_q;
        access    = reqLat_q;
        memEn     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.req) begin
                    reqLat_d  = incoming;
                    access    = incoming;
                    waitCnt_d = CNT_INIT;
                    if (LATENCY == 0) begin
                        state_d = RESP;
                        memEn   = !incoming.fault;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (waitCnt_q == '0) begin
                    state_d = RESP;
                    memEn   = !reqLat_q.fault;
                end else begin
                    waitCnt_d = waitCnt_q - 1'b1;
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        ready_d = (state_d == RESP);
        err_d   = ready_d && access.fault;
        rdSel_d = ready_d && !access.fault && !access.we;
    end

    // State, latch and registered outputs; reset drops any uncommitted request.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            waitCnt_q <= '0;
            reqLat_q  <= '0;
            ready_q   <= 1'b0;
            err_q     <= 1'b0;
            rdSel_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            waitCnt_q <= waitCnt_d;
            reqLat_q  <= reqLat_d;
            ready_q   <= ready_d;
            err_q     <= err_d;
            rdSel_q   <= rdSel_d;
        end
    end

    mem_array #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_array (
        .clk_i   (clk_i),
        .en_i    (memEn),
        .we_i    (access.we),
        .wstrb_i (access.wstrb),
        .waddr_i (access.addr[AW+1:2]),
        .wdata_i (access.wdata),
        .rdata_o (arrRdata)
    );

    assign unusedAddrBits = ^{access.addr[31:AW+2], access.addr[1:0]};

    assign bus.ready = ready_q;
    assign bus.err   = err_q;
    assign bus.rdata = rdSel_q ? arrRdata : 32'h0;

endmodule

// File: tb/tb_mem_responder.sv
// Bench for mem_responder: one LATENCY=2 and one LATENCY=0 instance against a word-array model.
module tb_mem_responder;

   localparam int DEPTH = 256;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   tests  = 0;
   int   failed = 0;

   logic [31:0] model2 [DEPTH];
   logic [31:0] model0 [DEPTH];

   // Free-running clock shared by both instances
   always #5 clk = ~clk;

   mem_responder_if bus2();
   mem_responder_if bus0();

   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(2)) dut2 (.clk_i(clk), .rst_i(rst), .bus(bus2));
   mem_responder #(.DEPTH_WORDS(DEPTH), .LATENCY(0)) dut0 (.clk_i(clk), .rst_i(rst), .bus(bus0));

   function automatic int latOf(input int sel);
      return (sel == 2) ? 2 : 0;
   endfunction

   task automatic drive(input int sel, input logic req, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb);
      if (sel == 2) begin
         bus2.req = req; bus2.we = we; bus2.addr = addr; bus2.wdata = wdata; bus2.wstrb = wstrb;
      end else begin
         bus0.req = req; bus0.we = we; bus0.addr = addr; bus0.wdata = wdata; bus0.wstrb = wstrb;
      end
   endtask

   task automatic sample(input int sel, output logic r, output logic e, output logic [31:0] d);
      if (sel == 2) begin
         r = bus2.ready; e = bus2.err; d = bus2.rdata;
      end else begin
         r = bus0.ready; e = bus0.err; d = bus0.rdata;
      end
   endtask

   // Word-memory reference: fault rules, byte lanes, read-back value
   task automatic modelAccess(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                              input logic [3:0] wstrb, output logic expErr, output logic [31:0] expRdata);
      int unsigned idx;
      logic [31:0] cur;
      idx = addr / 4;
      expErr = (addr % 4 != 0) || (idx >= DEPTH);
      expRdata = 32'h0;
      if (expErr) return;
      cur = (sel == 2) ? model2[idx] : model0[idx];
      if (we) begin
         for (int b = 0; b < 4; b++)
            if (wstrb[b]) cur[8*b +: 8] = wdata[8*b +: 8];
         if (sel == 2) model2[idx] = cur; else model0[idx] = cur;
      end else begin
         expRdata = cur;
      end
   endtask

   // One request: edges counts the accepting edge as 1; readyAfter is ready one edge after the pulse
   task automatic transact(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                           input logic [3:0] wstrb, input bit scramble, output int edges,
                           output logic [31:0] rdata, output logic err, output logic readyAfter);
      logic r, e;
      logic [31:0] d;
      edges = -1; rdata = 32'h0; err = 1'b0; readyAfter = 1'b0;
      @(negedge clk);
      drive(sel, 1'b1, we, addr, wdata, wstrb);
      @(posedge clk);
      #1;
      for (int n = 1; n <= 20; n++) begin
         sample(sel, r, e, d);
         if (r === 1'b1) begin
            edges = n; rdata = d; err = e;
            break;
         end
         if (scramble) drive(sel, 1'b1, ~we, $urandom, $urandom, 4'($urandom));
         @(posedge clk);
         #1;
      end
      @(negedge clk);
      drive(sel, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      @(posedge clk);
      #1;
      sample(sel, r, e, d);
      readyAfter = r;
   endtask

   task automatic runOp(input int sel, input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [3:0] wstrb, input bit scramble, output int edges, output logic [31:0] rdata,
                        output logic err, output logic readyAfter, output logic expErr, output logic [31:0] expRdata);
      transact(sel, we, addr, wdata, wstrb, scramble, edges, rdata, err, readyAfter);
      modelAccess(sel, we, addr, wdata, wstrb, expErr, expRdata);
   endtask

   task automatic test_reset();
      logic r, e;
      logic [31:0] d;
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      drive(0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst = 1'b1;
      #1;
      for (int s = 0; s <= 2; s += 2) begin
         sample(s, r, e, d);
         tests++;
         if ({r, e, d} !== 34'h0) begin
            failed++;
            $display("[TB] FAIL reset_outputs dut%0d: got ready=%b err=%b rdata=%h, expected all 0", s, r, e, d);
         end
      end
      @(negedge clk);
      rst = 1'b0;
   endtask

   task automatic test_fill();
      int edges;
      logic [31:0] rd, expRd, data;
      logic er, ra, expEr;
      for (int s = 0; s <= 2; s += 2) begin
         for (int i = 0; i < DEPTH; i++) begin
            data = $urandom;
            runOp(s, 1'b1, 32'(i * 4), data, 4'hF, 1'b0, edges, rd, er, ra, expEr, expRd);
            tests++;
            if (edges !== latOf(s) + 1 || er !== 1'b0 || rd !== 32'h0) begin
               failed++;
               $display("[TB] FAIL fill dut%0d word %0d: got edges=%0d err=%b rdata=%h, expected edges=%0d err=0 rdata=0",
                        s, i, edges, er, rd, latOf(s) + 1);
            end
         end
      end
   endtask

   task automatic test_store_load();
      int edges;
      logic [31:0] rd, expRd;
      logic er, ra, expEr;
      runOp(2, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (edges !== 3) begin
         failed++; $display("[TB] FAIL store_latency: got %0d edges, expected 3", edges);
      end
      tests++;
      if (er !== 1'b0) begin
         failed++; $display("[TB] FAIL store_err: got %b, expected 0", er);
      end
      tests++;
      if (ra !== 1'b0) begin
         failed++; $display("[TB] FAIL ready_pulse_width: ready got %b one edge later, expected 0", ra);
      end
      runOp(2, 1'b0, 32'h10, 32'h0, 4'h0, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
         failed++; $display("[TB] FAIL load_after_store: got rdata=%h err=%b, expected DEADBEEF err=0", rd, er);
      end
   endtask

   task automatic test_byte_mask();
      int edges;
      logic [31:0] rd, expRd;
      logic er, ra, expEr;
      runOp(2, 1'b1, 32'h20, 32'h11223344, 4'b1111, 1'b0, edges, rd, er, ra, expEr, expRd);
      runOp(2, 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 1'b0, edges, rd, er, ra, expEr, expRd);
      runOp(2, 1'b0, 32'h20, 32'h0, 4'h0, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (rd !== 32'h11BB33DD) begin
         failed++; $display("[TB] FAIL byte_mask: got %h, expected 11BB33DD", rd);
      end
   endtask

   task automatic test_errors();
      int edges;
      logic [31:0] rd, expRd, word0;
      logic er, ra, expEr;
      word0 = model2[0];
      runOp(2, 1'b0, 32'h22, 32'h0, 4'h0, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (er !== 1'b1 || rd !== 32'h0 || edges !== 3) begin
         failed++; $display("[TB] FAIL misaligned_load: got err=%b rdata=%h edges=%0d, expected err=1 rdata=0 edges=3", er, rd, edges);
      end
      runOp(2, 1'b1, 32'h400, 32'hCAFEF00D, 4'hF, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (er !== 1'b1 || edges !== 3) begin
         failed++; $display("[TB] FAIL range_store: got err=%b edges=%0d, expected err=1 edges=3", er, edges);
      end
      runOp(2, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (rd !== word0 || er !== 1'b0) begin
         failed++; $display("[TB] FAIL load_after_fault: got rdata=%h err=%b, expected %h err=0", rd, er, word0);
      end
   endtask

   task automatic test_back_to_back();
      logic [31:0] addrA, addrB, dA, dB, d;
      logic eA, eB, r, e;
      int lat, rdyA, rdyB, seen;
      addrA = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      addrB = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      modelAccess(2, 1'b0, addrA, 32'h0, 4'h0, eA, dA);
      modelAccess(2, 1'b0, addrB, 32'h0, 4'h0, eB, dB);
      lat  = latOf(2);
      rdyA = lat;
      rdyB = rdyA + 2 + lat;
      seen = 0;
      @(negedge clk);
      drive(2, 1'b1, 1'b0, addrA, 32'h0, 4'h0);
      for (int k = 0; k <= rdyB + 3; k++) begin
         @(posedge clk);
         #1;
         sample(2, r, e, d);
         tests++;
         if (r !== ((k == rdyA) || (k == rdyB))) begin
            failed++; $display("[TB] FAIL b2b_ready edge %0d: got %b, expected %b", k, r, (k == rdyA) || (k == rdyB));
         end
         if (r === 1'b1) seen++;
         if (k == rdyA) begin
            tests++;
            if (d !== dA) begin
               failed++; $display("[TB] FAIL b2b_first_data: got %h, expected %h", d, dA);
            end
            @(negedge clk);
            drive(2, 1'b1, 1'b0, addrB, 32'h0, 4'h0);
         end
         if (k == rdyB) begin
            tests++;
            if (d !== dB) begin
               failed++; $display("[TB] FAIL b2b_second_data: got %h, expected %h", d, dB);
            end
            @(negedge clk);
            drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
         end
      end
      tests++;
      if (seen !== 2) begin
         failed++; $display("[TB] FAIL b2b_pulse_count: got %0d, expected 2", seen);
      end
   endtask

   task automatic test_reset_mid_op();
      int edges;
      logic [31:0] rd, expRd, pre, d, loadAddr;
      logic er, ra, expEr, r, e;
      pre = model2[32'h30 / 4];
      @(negedge clk);
      drive(2, 1'b1, 1'b1, 32'h30, ~pre, 4'hF);
      @(posedge clk);
      #3;
      rst = 1'b1;
      #1;
      sample(2, r, e, d);
      tests++;
      if ({r, e, d} !== 34'h0) begin
         failed++; $display("[TB] FAIL reset_mid_wait: got ready=%b err=%b rdata=%h, expected all 0", r, e, d);
      end
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst = 1'b0;
      runOp(2, 1'b0, 32'h30, 32'h0, 4'h0, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (rd !== pre || er !== 1'b0) begin
         failed++; $display("[TB] FAIL dropped_store: got rdata=%h err=%b, expected %h err=0", rd, er, pre);
      end
      // Reset during the response cycle must clear the pulse immediately
      loadAddr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      modelAccess(2, 1'b0, loadAddr, 32'h0, 4'h0, expEr, expRd);
      @(negedge clk);
      drive(2, 1'b1, 1'b0, loadAddr, 32'h0, 4'h0);
      r = 1'b0;
      for (int n = 0; n < 20 && r !== 1'b1; n++) begin
         @(posedge clk);
         #1;
         sample(2, r, e, d);
      end
      tests++;
      if (r !== 1'b1 || d !== expRd) begin
         failed++; $display("[TB] FAIL pre_reset_resp: got ready=%b rdata=%h, expected 1 and %h", r, d, expRd);
      end
      #2;
      rst = 1'b1;
      #1;
      sample(2, r, e, d);
      tests++;
      if ({r, e, d} !== 34'h0) begin
         failed++; $display("[TB] FAIL reset_in_resp: got ready=%b err=%b rdata=%h, expected all 0", r, e, d);
      end
      @(negedge clk);
      drive(2, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
      rst = 1'b0;
   endtask

   task automatic test_latency0();
      int edges;
      logic [31:0] rd, expRd, addr, saved;
      logic er, ra, expEr;
      addr  = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
      saved = model0[addr / 4];
      runOp(0, 1'b0, addr, 32'h0, 4'h0, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (edges !== 1 || rd !== saved || er !== 1'b0) begin
         failed++; $display("[TB] FAIL lat0_load: got edges=%0d rdata=%h err=%b, expected 1 %h 0", edges, rd, er, saved);
      end
      runOp(0, 1'b1, addr, ~saved, 4'b0000, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (edges !== 1 || er !== 1'b0 || rd !== 32'h0 || ra !== 1'b0) begin
         failed++; $display("[TB] FAIL lat0_nop_store: got edges=%0d err=%b rdata=%h after=%b, expected 1 0 0 0", edges, er, rd, ra);
      end
      runOp(0, 1'b0, addr, 32'h0, 4'h0, 1'b0, edges, rd, er, ra, expEr, expRd);
      tests++;
      if (rd !== saved) begin
         failed++; $display("[TB] FAIL lat0_nop_unchanged: got %h, expected %h", rd, saved);
      end
   endtask

   task automatic test_random();
      int edges, sel;
      logic [31:0] rd, expRd, addr, wdata;
      logic er, ra, expEr, we;
      logic [3:0] wstrb;
      bit scramble;
      for (int i = 0; i < 200; i++) begin
         sel      = ($urandom_range(0, 1) == 0) ? 2 : 0;
         we       = 1'($urandom_range(0, 1));
         wdata    = $urandom;
         wstrb    = 4'($urandom);
         scramble = 1'($urandom_range(0, 1));
         case ($urandom_range(0, 9))
            0:       addr = {22'd0, 8'($urandom_range(0, 255)), 2'($urandom_range(1, 3))};
            1:       addr = {30'($urandom_range(DEPTH, 32'h3FFF_FFFF)), 2'b00};
            default: addr = {22'd0, 8'($urandom_range(0, 255)), 2'b00};
         endcase
         runOp(sel, we, addr, wdata, wstrb, scramble, edges, rd, er, ra, expEr, expRd);
         tests++;
         if (edges !== latOf(sel) + 1) begin
            failed++; $display("[TB] FAIL rand%0d latency dut%0d: got %0d, expected %0d", i, sel, edges, latOf(sel) + 1);
         end
         tests++;
         if (er !== expEr) begin
            failed++; $display("[TB] FAIL rand%0d err dut%0d addr %h: got %b, expected %b", i, sel, addr, er, expEr);
         end
         tests++;
         if (rd !== expRd) begin
            failed++; $display("[TB] FAIL rand%0d rdata dut%0d addr %h: got %h, expected %h", i, sel, addr, rd, expRd);
         end
         tests++;
         if (ra !== 1'b0) begin
            failed++; $display("[TB] FAIL rand%0d pulse dut%0d: ready got %b after pulse, expected 0", i, sel, ra);
         end
      end
   endtask

   // Sequence of scenarios, then the summary
   initial begin
      test_reset();
      test_fill();
      test_store_load();
      test_byte_mask();
      test_errors();
      test_back_to_back();
      test_reset_mid_op();
      test_latency0();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
   end

   // Guard against a hung handshake
   initial begin
      #2000000;
      $display("[TB] FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule
